// File: rtl/rx_ordered_set_parser.sv
// rx_ordered_set_parser
// Parses Gen1/Gen2 8b/10b training ordered sets (TS1/TS2) and EIOS from the
// registered PIPE receive stream and presents the extracted fields to the LTSSM.
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   GEN                             active generation (1: slot 0 only, 2: slots 0,1)
//   PIPEDataValid/PIPEData/PIPEDataK  received symbols, slot 0 earliest
//   PIPEElectricalIdle              receiver electrical idle (forces hunt)
//   TSValid                         one-cycle pulse per completed TS
//   TSType, LinkNum, LaneNum, LinkPad, LanePad, NFTS, RateID, TrainCtrl
//                                   fields of the last completed TS
//   TSConsecCount                   consecutive identical TS count (saturating)
//   EIOSDetected                    one-cycle pulse per completed EIOS
module rx_ordered_set_parser (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  GEN,
  input  logic        PIPEDataValid,
  input  logic [31:0] PIPEData,
  input  logic [3:0]  PIPEDataK,
  input  logic        PIPEElectricalIdle,
  output logic        TSValid,
  output logic        TSType,
  output logic [7:0]  LinkNum,
  output logic [7:0]  LaneNum,
  output logic        LinkPad,
  output logic        LanePad,
  output logic [7:0]  NFTS,
  output logic [7:0]  RateID,
  output logic [7:0]  TrainCtrl,
  output logic [3:0]  TSConsecCount,
  output logic        EIOSDetected
);

  localparam int unsigned SYM_W = 8;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic [SYM_W-1:0] SYM_COM = 8'hBC;
  localparam logic [SYM_W-1:0] SYM_PAD = 8'hF7;
  localparam logic [SYM_W-1:0] SYM_IDL = 8'h7C;
  localparam logic [SYM_W-1:0] TS1_ID  = 8'h4A;
  localparam logic [SYM_W-1:0] TS2_ID  = 8'h45;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_PEND = 2'd1,
    S_TS   = 2'd2,
    S_EIOS = 2'd3
  } state_t;

  // parser state and in-progress set fields
  state_t           st_q, st_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SYM_W-1:0] link_w_q, link_w_d;
  logic [SYM_W-1:0] lane_w_q, lane_w_d;
  logic             link_pad_w_q, link_pad_w_d;
  logic             lane_pad_w_q, lane_pad_w_d;
  logic [SYM_W-1:0] nfts_w_q, nfts_w_d;
  logic [SYM_W-1:0] rate_w_q, rate_w_d;
  logic [SYM_W-1:0] ctrl_w_q, ctrl_w_d;
  logic [SYM_W-1:0] id_w_q, id_w_d;

  // registered outputs
  logic             ts_valid_q, ts_valid_d;
  logic             ts_type_q, ts_type_d;
  logic [SYM_W-1:0] link_q, link_d;
  logic [SYM_W-1:0] lane_q, lane_d;
  logic             link_pad_q, link_pad_d;
  logic             lane_pad_q, lane_pad_d;
  logic [SYM_W-1:0] nfts_q, nfts_d;
  logic [SYM_W-1:0] rate_q, rate_d;
  logic [SYM_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eios_q, eios_d;

  logic             active;
  logic             two_slot;
  logic             ts_done;
  logic             eios_done;
  logic             abort;
  logic             sym_k;
  logic [SYM_W-1:0] sym;
  logic             new_type;
  logic             same_ts;
  logic             unused_upper_slots;

  assign active   = ((GEN == 3'd1) || (GEN == 3'd2)) && !PIPEElectricalIdle;
  assign two_slot = (GEN == 3'd2);

  // slots 2 and 3 only carry symbols at Gen3+, where this block is idle
  assign unused_upper_slots = ^{PIPEData[31:16], PIPEDataK[3:2]};

  // symbol parser: slot 0 then slot 1, the state after slot 0 feeding slot 1
  always_comb begin
    st_d         = st_q;
    idx_d        = idx_q;
    link_w_d     = link_w_q;
    lane_w_d     = lane_w_q;
    link_pad_w_d = link_pad_w_q;
    lane_pad_w_d = lane_pad_w_q;
    nfts_w_d     = nfts_w_q;
    rate_w_d     = rate_w_q;
    ctrl_w_d     = ctrl_w_q;
    id_w_d       = id_w_q;
    ts_done      = 1'b0;
    eios_done    = 1'b0;
    abort        = 1'b0;
    sym          = '0;
    sym_k        = 1'b0;

    if (!active) begin
      st_d  = S_HUNT;
      idx_d = '0;
    end else if (PIPEDataValid) begin
      for (int s = 0; s < 2; s++) begin
        if ((s == 0) || two_slot) begin
          sym   = PIPEData[8*s +: 8];
          sym_k = PIPEDataK[s];
          abort = 1'b0;
          case (st_d)
            S_HUNT: begin
              if (sym_k && (sym == SYM_COM)) begin
                st_d  = S_PEND;
                idx_d = 4'd1;
              end
            end
            // symbol 1 decides between EIOS and TS
            S_PEND: begin
              if (sym_k && (sym == SYM_IDL)) begin
                st_d  = S_EIOS;
                idx_d = 4'd2;
              end else if (!sym_k || (sym == SYM_PAD)) begin
                st_d         = S_TS;
                idx_d        = 4'd2;
                link_w_d     = sym;
                link_pad_w_d = sym_k;
              end else begin
                abort = 1'b1;
              end
            end
            S_TS: begin
              if (idx_d == 4'd2) begin
                if (!sym_k || (sym == SYM_PAD)) begin
                  lane_w_d     = sym;
                  lane_pad_w_d = sym_k;
                  idx_d        = 4'd3;
                end else begin
                  abort = 1'b1;
                end
              end else if (idx_d <= 4'd5) begin
                if (sym_k) begin
                  abort = 1'b1;
                end else begin
                  case (idx_d)
                    4'd3:    nfts_w_d = sym;
                    4'd4:    rate_w_d = sym;
                    default: ctrl_w_d = sym;
                  endcase
                  idx_d = idx_d + 4'd1;
                end
              end else if (idx_d == 4'd6) begin
                if (!sym_k && ((sym == TS1_ID) || (sym == TS2_ID))) begin
                  id_w_d = sym;
                  idx_d  = 4'd7;
                end else begin
                  abort = 1'b1;
                end
              end else begin
                // identifier symbols 7..15 repeat symbol 6
                if (!sym_k && (sym == id_w_d)) begin
                  if (idx_d == 4'd15) begin
                    ts_done = 1'b1;
                    st_d    = S_HUNT;
                    idx_d   = '0;
                  end else begin
                    idx_d = idx_d + 4'd1;
                  end
                end else begin
                  abort = 1'b1;
                end
              end
            end
            S_EIOS: begin
              if (sym_k && (sym == SYM_IDL)) begin
                if (idx_d == 4'd3) begin
                  eios_done = 1'b1;
                  st_d      = S_HUNT;
                  idx_d     = '0;
                end else begin
                  idx_d = idx_d + 4'd1;
                end
              end else begin
                abort = 1'b1;
              end
            end
            default: begin
              st_d  = S_HUNT;
              idx_d = '0;
            end
          endcase

          // an aborting COM is itself the start of a new set
          if (abort) begin
            if (sym_k && (sym == SYM_COM)) begin
              st_d  = S_PEND;
              idx_d = 4'd1;
            end else begin
              st_d  = S_HUNT;
              idx_d = '0;
            end
          end
        end
      end
    end
  end

  assign new_type = (id_w_d == TS2_ID);

  // completed set compared against the previously reported one
  assign same_ts = (new_type == ts_type_q) && (link_w_d == link_q) &&
                   (lane_w_d == lane_q) && (link_pad_w_d == link_pad_q) &&
                   (lane_pad_w_d == lane_pad_q) && (nfts_w_d == nfts_q) &&
                   (rate_w_d == rate_q) && (ctrl_w_d == ctrl_q);

  // output update on completion
  always_comb begin
    ts_valid_d = ts_done;
    eios_d     = eios_done;
    ts_type_d  = ts_type_q;
    link_d     = link_q;
    lane_d     = lane_q;
    link_pad_d = link_pad_q;
    lane_pad_d = lane_pad_q;
    nfts_d     = nfts_q;
    rate_d     = rate_q;
    ctrl_d     = ctrl_q;
    cnt_d      = cnt_q;

    if (!active) begin
      cnt_d = '0;
    end else if (ts_done) begin
      ts_type_d  = new_type;
      link_d     = link_w_d;
      lane_d     = lane_w_d;
      link_pad_d = link_pad_w_d;
      lane_pad_d = lane_pad_w_d;
      nfts_d     = nfts_w_d;
      rate_d     = rate_w_d;
      ctrl_d     = ctrl_w_d;
      if (same_ts && (cnt_q != '0)) begin
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd1;
      end
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= S_HUNT;
      idx_q        <= '0;
      link_w_q     <= '0;
      lane_w_q     <= '0;
      link_pad_w_q <= 1'b0;
      lane_pad_w_q <= 1'b0;
      nfts_w_q     <= '0;
      rate_w_q     <= '0;
      ctrl_w_q     <= '0;
      id_w_q       <= '0;
      ts_valid_q   <= 1'b0;
      ts_type_q    <= 1'b0;
      link_q       <= '0;
      lane_q       <= '0;
      link_pad_q   <= 1'b0;
      lane_pad_q   <= 1'b0;
      nfts_q       <= '0;
      rate_q       <= '0;
      ctrl_q       <= '0;
      cnt_q        <= '0;
      eios_q       <= 1'b0;
    end else begin
      st_q         <= st_d;
      idx_q        <= idx_d;
      link_w_q     <= link_w_d;
      lane_w_q     <= lane_w_d;
      link_pad_w_q <= link_pad_w_d;
      lane_pad_w_q <= lane_pad_w_d;
      nfts_w_q     <= nfts_w_d;
      rate_w_q     <= rate_w_d;
      ctrl_w_q     <= ctrl_w_d;
      id_w_q       <= id_w_d;
      ts_valid_q   <= ts_valid_d;
      ts_type_q    <= ts_type_d;
      link_q       <= link_d;
      lane_q       <= lane_d;
      link_pad_q   <= link_pad_d;
      lane_pad_q   <= lane_pad_d;
      nfts_q       <= nfts_d;
      rate_q       <= rate_d;
      ctrl_q       <= ctrl_d;
      cnt_q        <= cnt_d;
      eios_q       <= eios_d;
    end
  end

  assign TSValid       = ts_valid_q;
  assign TSType        = ts_type_q;
  assign LinkNum       = link_q;
  assign LaneNum       = lane_q;
  assign LinkPad       = link_pad_q;
  assign LanePad       = lane_pad_q;
  assign NFTS          = nfts_q;
  assign RateID        = rate_q;
  assign TrainCtrl     = ctrl_q;
  assign TSConsecCount = cnt_q;
  assign EIOSDetected  = eios_q;

endmodule

// File: tb/tb_rx_ordered_set_parser.sv
module tb_rx_ordered_set_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  GEN;
  logic        PIPEDataValid;
  logic [31:0] PIPEData;
  logic [3:0]  PIPEDataK;
  logic        PIPEElectricalIdle;
  logic        TSValid;
  logic        TSType;
  logic [7:0]  LinkNum;
  logic [7:0]  LaneNum;
  logic        LinkPad;
  logic        LanePad;
  logic [7:0]  NFTS;
  logic [7:0]  RateID;
  logic [7:0]  TrainCtrl;
  logic [3:0]  TSConsecCount;
  logic        EIOSDetected;

  rx_ordered_set_parser dut (
    .clk                (clk),
    .reset              (reset),
    .GEN                (GEN),
    .PIPEDataValid      (PIPEDataValid),
    .PIPEData           (PIPEData),
    .PIPEDataK          (PIPEDataK),
    .PIPEElectricalIdle (PIPEElectricalIdle),
    .TSValid            (TSValid),
    .TSType             (TSType),
    .LinkNum            (LinkNum),
    .LaneNum            (LaneNum),
    .LinkPad            (LinkPad),
    .LanePad            (LanePad),
    .NFTS               (NFTS),
    .RateID             (RateID),
    .TrainCtrl          (TrainCtrl),
    .TSConsecCount      (TSConsecCount),
    .EIOSDetected       (EIOSDetected)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int ts_seen   = 0;
  int eios_seen = 0;
  int last_ts   = 0;

  logic [7:0] ts_sym [16];
  logic       ts_k   [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance one cycle; outputs are read at the falling edge
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (TSValid === 1'b1) begin
      ts_seen++;
      last_ts = cyc;
    end
    if (EIOSDetected === 1'b1) eios_seen++;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k);
    PIPEDataValid = v;
    PIPEData      = d;
    PIPEDataK     = k;
    tick();
  endtask

  task automatic build_ts(input logic t, input logic [7:0] link, input logic [7:0] lane,
                          input logic lkpad, input logic lnpad,
                          input logic [7:0] nfts, input logic [7:0] rate, input logic [7:0] ctrl);
    ts_sym[0] = 8'hBC;                  ts_k[0] = 1'b1;
    ts_sym[1] = lkpad ? 8'hF7 : link;   ts_k[1] = lkpad;
    ts_sym[2] = lnpad ? 8'hF7 : lane;   ts_k[2] = lnpad;
    ts_sym[3] = nfts;                   ts_k[3] = 1'b0;
    ts_sym[4] = rate;                   ts_k[4] = 1'b0;
    ts_sym[5] = ctrl;                   ts_k[5] = 1'b0;
    for (int i = 6; i < 16; i++) begin
      ts_sym[i] = t ? 8'h45 : 8'h4A;
      ts_k[i]   = 1'b0;
    end
  endtask

  task automatic send_gen1(input int first, input int last);
    for (int i = first; i <= last; i++)
      drive(1'b1, {24'h0, ts_sym[i]}, {3'b000, ts_k[i]});
  endtask

  task automatic send_gen2(input int first, input int last);
    for (int c = first; c <= last; c++)
      drive(1'b1, {16'h0, ts_sym[2*c+1], ts_sym[2*c]}, {2'b00, ts_k[2*c+1], ts_k[2*c]});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tsvalid"}, TSValid, 0);
    chk({tag, "_tstype"}, TSType, 0);
    chk({tag, "_link"}, LinkNum, 0);
    chk({tag, "_lane"}, LaneNum, 0);
    chk({tag, "_linkpad"}, LinkPad, 0);
    chk({tag, "_lanepad"}, LanePad, 0);
    chk({tag, "_nfts"}, NFTS, 0);
    chk({tag, "_rate"}, RateID, 0);
    chk({tag, "_ctrl"}, TrainCtrl, 0);
    chk({tag, "_count"}, TSConsecCount, 0);
    chk({tag, "_eios"}, EIOSDetected, 0);
  endtask

  initial begin
    int prev;
    int seen0;
    int eseen0;
    int start;

    reset = 1'b1;
    GEN = 3'd1;
    PIPEDataValid = 1'b0;
    PIPEData = '0;
    PIPEDataK = '0;
    PIPEElectricalIdle = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();

    // Gen1: four identical TS1
    build_ts(1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h20, 8'h02, 8'h00);
    for (int n = 0; n < 4; n++) begin
      prev = last_ts;
      seen0 = ts_seen;
      send_gen1(0, 15);
      chk("g1_tsvalid", TSValid, 1);
      chk("g1_pulses", ts_seen - seen0, 1);
      chk("g1_count", TSConsecCount, n + 1);
      if (n > 0) chk("g1_interval", last_ts - prev, 16);
    end
    chk("g1_type", TSType, 0);
    chk("g1_link", LinkNum, 8'h01);
    chk("g1_lane", LaneNum, 8'h00);
    chk("g1_linkpad", LinkPad, 0);
    chk("g1_lanepad", LanePad, 0);
    chk("g1_nfts", NFTS, 8'h20);
    chk("g1_rate", RateID, 8'h02);
    chk("g1_ctrl", TrainCtrl, 8'h00);
    tick();
    chk("g1_pulse_clear", TSValid, 0);

    // Gen2: 18 identical TS2 with PAD link/lane, count saturates
    GEN = 3'd2;
    build_ts(1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'h02, 8'h00);
    for (int n = 1; n <= 18; n++) begin
      prev = last_ts;
      seen0 = ts_seen;
      send_gen2(0, 7);
      chk("g2_tsvalid", TSValid, 1);
      chk("g2_pulses", ts_seen - seen0, 1);
      chk("g2_count", TSConsecCount, (n > 15) ? 15 : n);
      if (n > 1) chk("g2_interval", last_ts - prev, 8);
    end
    chk("g2_type", TSType, 1);
    chk("g2_linkpad", LinkPad, 1);
    chk("g2_lanepad", LanePad, 1);
    chk("g2_link", LinkNum, 8'hF7);
    chk("g2_lane", LaneNum, 8'hF7);
    chk("g2_nfts", NFTS, 8'h10);

    // Gen1: bad identifier at symbol 9, then a good TS1
    GEN = 3'd1;
    build_ts(1'b0, 8'h03, 8'h01, 1'b0, 1'b0, 8'h18, 8'h02, 8'h00);
    ts_sym[9] = 8'h45;
    seen0 = ts_seen;
    send_gen1(0, 15);
    chk("abort_nopulse", ts_seen - seen0, 0);
    build_ts(1'b0, 8'h03, 8'h01, 1'b0, 1'b0, 8'h18, 8'h02, 8'h00);
    send_gen1(0, 15);
    chk("abort_next_tsvalid", TSValid, 1);
    chk("abort_next_pulses", ts_seen - seen0, 1);
    chk("abort_next_count", TSConsecCount, 1);
    chk("abort_next_type", TSType, 0);
    chk("abort_next_link", LinkNum, 8'h03);
    chk("abort_next_lane", LaneNum, 8'h01);
    chk("abort_next_nfts", NFTS, 8'h18);

    // Gen2: 3-cycle valid gap mid-TS1 (invalid cycles carry COMs that must be ignored)
    GEN = 3'd2;
    start = cyc;
    seen0 = ts_seen;
    send_gen2(0, 2);
    for (int g = 0; g < 3; g++) drive(1'b0, 32'hBCBC_BCBC, 4'hF);
    send_gen2(3, 7);
    chk("gap_tsvalid", TSValid, 1);
    chk("gap_pulses", ts_seen - seen0, 1);
    chk("gap_latency", last_ts - start, 11);
    chk("gap_count", TSConsecCount, 2);

    // Gen1: EIOS, then electrical idle clears the count
    GEN = 3'd1;
    seen0 = ts_seen;
    eseen0 = eios_seen;
    drive(1'b1, 32'h0000_00BC, 4'h1);
    drive(1'b1, 32'h0000_007C, 4'h1);
    drive(1'b1, 32'h0000_007C, 4'h1);
    drive(1'b1, 32'h0000_007C, 4'h1);
    chk("eios_pulse", EIOSDetected, 1);
    drive(1'b1, 32'h0, 4'h0);
    chk("eios_pulse_clear", EIOSDetected, 0);
    chk("eios_pulses", eios_seen - eseen0, 1);
    chk("eios_no_ts", ts_seen - seen0, 0);
    chk("eios_count_kept", TSConsecCount, 2);
    PIPEElectricalIdle = 1'b1;
    drive(1'b1, 32'h0, 4'h0);
    drive(1'b1, 32'h0, 4'h0);
    chk("eidle_count", TSConsecCount, 0);
    chk("eidle_link_hold", LinkNum, 8'h03);
    PIPEElectricalIdle = 1'b0;
    send_gen1(0, 15);
    chk("eidle_next_tsvalid", TSValid, 1);
    chk("eidle_next_count", TSConsecCount, 1);

    // Gen1: GEN invalid for one cycle mid-set abandons it and clears the count
    seen0 = ts_seen;
    send_gen1(0, 7);
    GEN = 3'd0;
    drive(1'b1, 32'h0000_00BC, 4'h1);
    chk("geninv_count", TSConsecCount, 0);
    GEN = 3'd1;
    send_gen1(8, 15);
    chk("geninv_nopulse", ts_seen - seen0, 0);
    chk("geninv_link_hold", LinkNum, 8'h03);

    // Gen2: reset mid-TS, then a fresh TS1
    GEN = 3'd2;
    send_gen2(0, 3);
    reset = 1'b1;
    send_gen2(4, 5);
    chk_zero("midreset");
    reset = 1'b0;
    seen0 = ts_seen;
    send_gen2(6, 7);
    chk("midreset_discard", ts_seen - seen0, 0);
    send_gen2(0, 7);
    chk("midreset_tsvalid", TSValid, 1);
    chk("midreset_count", TSConsecCount, 1);
    chk("midreset_link", LinkNum, 8'h03);
    chk("midreset_rate", RateID, 8'h02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
